// File: rtl/decimal_pkg.sv
// Shared decimal definitions for the keypad encoder and the display decoder.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
package decimal_pkg;

   localparam int NIBBLE_W = 4;

   // Reverse double-dabble correction: nibbles at or above 8 after a right shift get 3 removed
   localparam logic [NIBBLE_W-1:0] BCD_ADJ       = 4'd3;
   localparam logic [NIBBLE_W-1:0] BCD_THRESH    = 4'd8;
   localparam logic [NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // 7-segment patterns, bit order gfedcba, active high
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   function automatic logic is_bcd_digit(input logic [NIBBLE_W-1:0] nib);
      return nib <= BCD_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// One BCD nibble correction step: subtract 3 when the nibble is 8 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_nibble_adjust
   import decimal_pkg::*;
(
   input  logic [NIBBLE_W-1:0] digit,
   output logic [NIBBLE_W-1:0] adjusted
);

   // Correction applied to the already-shifted nibble
   always_comb begin
      adjusted = (digit >= BCD_THRESH) ? (digit - BCD_ADJ) : digit;
   end

endmodule

// File: rtl/bcd_to_binary_encoder.sv
// Packed BCD to saturated unsigned binary via iterative reverse double-dabble.
// Latency: start at edge k gives done for the cycle after edge k+4*NUM_DIGITS+1.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped. Optional DIGIT_CHECK_EN flags digits above 9.
module bcd_to_binary_encoder
   import decimal_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int BIN_W      = 8
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] bcd_in,
   output logic                         busy,
   output logic                         done,
   output logic [BIN_W-1:0]             result,
   output logic                         ovf,
   output logic                         err
);

   localparam int W     = NIBBLE_W * NUM_DIGITS;
   localparam int CNT_W = $clog2(W) + 1;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(W - 1);

   state_t            state;
   state_t            next_state;
   logic              load;
   logic              shift_en;
   logic              finish;
   logic [CNT_W-1:0]  cnt;
   logic [W-1:0]      bcd_reg;
   logic [W-1:0]      bin_reg;
   logic [W-1:0]      bcd_shift;
   logic [W-1:0]      bcd_adj;
   logic [W+BIN_W-1:0] bin_wide;
   logic              sat_ovf;
   logic [BIN_W-1:0]  sat_val;
   logic [BIN_W-1:0]  fin_result;
   logic              fin_ovf;

   assign bcd_shift = bcd_reg >> 1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_nibble_adjust u_adj (
         .digit    (bcd_shift[g*NIBBLE_W +: NIBBLE_W]),
         .adjusted (bcd_adj[g*NIBBLE_W +: NIBBLE_W])
      );
   end

   // Saturate the full-width binary value into the result width
   always_comb begin
      bin_wide = {{BIN_W{1'b0}}, bin_reg};
      sat_ovf  = (bin_wide >> BIN_W) != '0;
      sat_val  = sat_ovf ? '1 : bin_wide[BIN_W-1:0];
   end

`ifdef DIGIT_CHECK_EN
   logic err_pending;
   logic invalid_in;

   // Any non-decimal digit in the request poisons that conversion
   always_comb begin
      invalid_in = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!is_bcd_digit(bcd_in[i*NIBBLE_W +: NIBBLE_W])) begin
            invalid_in = 1'b1;
         end
      end
   end

   // Remember the digit error from acceptance until the result is published
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         err_pending <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (load) begin
            err_pending <= invalid_in;
         end
         if (finish) begin
            err <= err_pending;
         end
      end
   end

   assign fin_result = err_pending ? '0 : sat_val;
   assign fin_ovf    = err_pending ? 1'b0 : sat_ovf;
`else
   assign err        = 1'b0;
   assign fin_result = sat_val;
   assign fin_ovf    = sat_ovf;
`endif

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Sequencing: accept in IDLE, 4N shifts, then one publish cycle
   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift_en   = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == LAST_SHIFT) begin
               next_state = DONE;
            end
         end
         DONE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Shift datapath and registered handshake/result outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bcd_reg <= '0;
         bin_reg <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         ovf     <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
         end else if (shift_en) begin
            bcd_reg <= bcd_adj;
            bin_reg <= {bcd_reg[0], bin_reg[W-1:1]};
            cnt     <= cnt + 1'b1;
         end
         if (finish) begin
            busy   <= 1'b0;
            result <= fin_result;
            ovf    <= fin_ovf;
         end
      end
   end

endmodule
